qsfp_i2c_arb: RTL and testbench

QSFP_I2C_ARB -- requirements
Module: qsfp_i2c_arb

---
 rtl/qsfp_i2c_arb.sv | 167 ++++++++++++++++
 tb/tb_qsfp_i2c_arb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsfp_i2c_arb.sv
// qsfp_i2c_arb: round-robin arbiter handing whole START..STOP TFR transactions from
// the poller (req0) or the host CSR path (req1) to one I2C master. Optional owner timeout: QSFP_I2C_ARB_TIMEOUT_EN.
module qsfp_i2c_arb #(
    parameter int unsigned TMO_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] gap_cycles,
    input  logic [9:0]  req0_data,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [9:0]  req1_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    output logic [9:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [1:0]  owner,
    output logic        busy,
    output logic        tmo_err
);

    if (TMO_CYCLES < 2 || TMO_CYCLES > 65535) begin : g_bad_tmo
        $error("qsfp_i2c_arb: TMO_CYCLES out of range 2..65535");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT0 = 3'd1,
        ST_GRANT1 = 3'd2,
        ST_GAP    = 3'd3
`ifdef QSFP_I2C_ARB_TIMEOUT_EN
        , ST_ABORT = 3'd4
`endif
    } state_t;

    state_t      state_q;
    state_t      end_state_s;
    logic        last_q;        // 1: req1 was served last
    logic [15:0] gap_cnt_q;
    logic [15:0] gap_load_s;
    logic        beat_s;
    logic        stop_s;

    // Output steering: the granted source is wired straight through to the master
    always_comb begin
        m_data     = 10'd0;
        m_valid    = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        owner      = 2'b00;
        case (state_q)
            ST_GRANT0: begin
                m_data     = req0_data;
                m_valid    = req0_valid;
                req0_ready = m_ready;
                owner      = 2'b01;
            end
            ST_GRANT1: begin
                m_data     = req1_data;
                m_valid    = req1_valid;
                req1_ready = m_ready;
                owner      = 2'b10;
            end
`ifdef QSFP_I2C_ARB_TIMEOUT_EN
            // Forced STOP so the bus is not left mid-transaction; last_q already names the aborted owner
            ST_ABORT: begin
                m_data  = 10'h100;
                m_valid = 1'b1;
                owner   = last_q ? 2'b10 : 2'b01;
            end
`endif
            default: begin
                m_data  = 10'd0;
                m_valid = 1'b0;
            end
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign beat_s      = m_valid & m_ready;
    assign stop_s      = m_data[8];
    assign end_state_s = (gap_cycles == 16'd0) ? ST_IDLE : ST_GAP;
    assign gap_load_s  = gap_cycles - 16'd1;

`ifdef QSFP_I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 2);
    logic [15:0] tmo_cnt_q;
    logic        tmo_err_q;
    assign tmo_err = tmo_err_q;
`else
    assign tmo_err = 1'b0;
`endif

    // Arbitration FSM with gap and owner-timeout counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            gap_cnt_q <= 16'd0;
`ifdef QSFP_I2C_ARB_TIMEOUT_EN
            tmo_cnt_q <= 16'd0;
            tmo_err_q <= 1'b0;
`endif
        end else begin
`ifdef QSFP_I2C_ARB_TIMEOUT_EN
            tmo_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
`ifdef QSFP_I2C_ARB_TIMEOUT_EN
                    tmo_cnt_q <= 16'd0;
`endif
                    if (req0_valid && (!req1_valid || last_q)) begin
                        state_q <= ST_GRANT0;
                    end else if (req1_valid) begin
                        state_q <= ST_GRANT1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (beat_s) begin
`ifdef QSFP_I2C_ARB_TIMEOUT_EN
                        tmo_cnt_q <= 16'd0;
`endif
                        if (stop_s) begin
                            state_q   <= end_state_s;
                            gap_cnt_q <= gap_load_s;
                            last_q    <= (state_q == ST_GRANT1);
                        end
                    end
`ifdef QSFP_I2C_ARB_TIMEOUT_EN
                    // Counter reaches TMO_CYCLES-1 on the same edge ABORT is entered
                    else if (tmo_cnt_q == TMO_LAST) begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                        state_q   <= ST_ABORT;
                        tmo_err_q <= 1'b1;
                        last_q    <= (state_q == ST_GRANT1);
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
`endif
                end
                ST_GAP: begin
                    if (gap_cnt_q == 16'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 16'd1;
                    end
                end
`ifdef QSFP_I2C_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    if (beat_s) begin
                        state_q   <= end_state_s;
                        gap_cnt_q <= gap_load_s;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qsfp_i2c_arb.sv
// Self-checking bench for qsfp_i2c_arb: directed protocol scenarios plus a randomized
// run scored against per-requester transaction queues.
module tb_qsfp_i2c_arb;

`ifdef QSFP_I2C_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 4096;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] gap_cycles;
    logic [9:0]  req0_data, req1_data, m_data;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic        m_valid, m_ready, busy, tmo_err;
    logic [1:0]  owner;

    always #5 clk = ~clk;

    qsfp_i2c_arb #(.TMO_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .gap_cycles(gap_cycles),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .owner(owner), .busy(busy), .tmo_err(tmo_err)
    );

    int n_run  = 0;
    int n_fail = 0;

    logic        s_mv, s_r0, s_r1, s_busy, s_tmo, s_beat;
    logic [9:0]  s_md;
    logic [1:0]  s_own;

    logic [9:0]  src0[$], src1[$], exp0[$], exp1[$];
    logic [9:0]  w[3] = '{10'h2A0, 10'h07F, 10'h102};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge; samples 1 time unit before the next rising edge.
    task automatic tick();
        #4;
        s_mv   = m_valid;
        s_md   = m_data;
        s_r0   = req0_ready;
        s_r1   = req1_ready;
        s_own  = owner;
        s_busy = busy;
        s_tmo  = tmo_err;
        s_beat = m_valid & m_ready;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 10'd0;
        req1_data  = 10'd0;
        m_ready    = 1'b0;
        gap_cycles = 16'd0;
        @(negedge clk);
        #1;
        check("rst_outputs", {m_valid, m_data, req0_ready, req1_ready, owner, busy, tmo_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic gen_txns();
        int          len;
        logic [9:0]  wd;
        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) begin
                wd    = 10'($urandom);
                wd[8] = (b == len - 1);
                if (t % 2 == 0) begin
                    src0.push_back(wd);
                    exp0.push_back(wd);
                end else begin
                    src1.push_back(wd);
                    exp1.push_back(wd);
                end
            end
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) begin
                wd    = 10'($urandom);
                wd[8] = (b == len - 1);
                if (t % 2 == 0) begin
                    src1.push_back(wd);
                    exp1.push_back(wd);
                end else begin
                    src0.push_back(wd);
                    exp0.push_back(wd);
                end
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         beats;
        logic [1:0] txn_own;

        // Three-beat poller transaction followed by a 3-cycle gap
        do_reset();
        gap_cycles = 16'd3;
        m_ready    = 1'b1;
        req0_valid = 1'b1;
        req0_data  = w[0];
        tick();
        check("idle_quiet", {s_mv, s_r0, s_r1, s_own, s_busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            req0_data = w[i];
            tick();
            check("seq_data", s_md, w[i]);
            check("seq_beat", s_beat, 1'b1);
            check("seq_owner", s_own, 2'b01);
        end
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_state", {s_busy, s_own, s_mv}, {1'b1, 2'b00, 1'b0});
        end
        tick();
        check("post_gap_idle", s_busy, 1'b0);

        // Simultaneous requests: round-robin from reset gives req0 first
        do_reset();
        m_ready    = 1'b1;
        req0_valid = 1'b1; req0_data = 10'h180;
        req1_valid = 1'b1; req1_data = 10'h1C5;
        tick();
        tick();
        check("rr_first_owner", s_own, 2'b01);
        check("rr_first_data", s_md, 10'h180);
        check("rr_first_r1", s_r1, 1'b0);
        req0_valid = 1'b0;
        tick();
        check("rr_between_owner", s_own, 2'b00);
        tick();
        check("rr_second_owner", s_own, 2'b10);
        check("rr_second_data", s_md, 10'h1C5);
        check("rr_second_r1", s_r1, 1'b1);
        req0_valid = 1'b1; req0_data = 10'h181;
        req1_data  = 10'h1C6;
        tick();
        tick();
        check("rr_third_owner", s_own, 2'b01);
        check("rr_third_data", s_md, 10'h181);
        req0_valid = 1'b0;
        tick();
        tick();
        check("rr_fourth_owner", s_own, 2'b10);
        check("rr_fourth_data", s_md, 10'h1C6);
        req1_valid = 1'b0;
        tick();

        // req1 arrives mid-transaction; req0 drops valid and stalls against m_ready
        do_reset();
        m_ready    = 1'b1;
        req0_valid = 1'b1; req0_data = 10'h2A0;
        tick();
        tick();
        check("mid_start_beat", {s_beat, s_md}, {1'b1, 10'h2A0});
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 10'h1FF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_hold", {s_r1, s_own, s_mv}, {1'b0, 2'b01, 1'b0});
        end
        req0_valid = 1'b1; req0_data = 10'h055;
        m_ready    = 1'b0;
        beats      = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            beats += int'(s_beat);
            check("stall_hold", {s_mv, s_md, s_r0, s_r1}, {1'b1, 10'h055, 1'b0, 1'b0});
        end
        check("stall_no_beats", beats, 0);
        m_ready = 1'b1;
        tick();
        check("stall_release", {s_beat, s_md}, {1'b1, 10'h055});
        req0_data = 10'h100;
        tick();
        check("mid_stop", {s_beat, s_md, s_r1}, {1'b1, 10'h100, 1'b0});
        req0_valid = 1'b0;
        tick();
        check("mid_idle_owner", s_own, 2'b00);
        tick();
        check("mid_req1_grant", {s_own, s_r1, s_md}, {2'b10, 1'b1, 10'h1FF});
        req1_valid = 1'b0;
        tick();

        // Reset in the middle of a transaction
        do_reset();
        m_ready    = 1'b1;
        req0_valid = 1'b1; req0_data = 10'h2A0;
        tick();
        tick();
        req0_data = 10'h033;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_outputs", {m_valid, m_data, req0_ready, req1_ready, owner, busy, tmo_err}, 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("midrst_no_stop", {s_mv, s_busy}, 2'b00);
        end
        req0_valid = 1'b1; req0_data = 10'h111;
        req1_valid = 1'b1; req1_data = 10'h122;
        tick();
        tick();
        check("midrst_rr_req0", {s_own, s_md}, {2'b01, 10'h111});
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();

`ifdef QSFP_I2C_ARB_TIMEOUT_EN
        // Owner goes silent after START: abort after TMO_CYCLES-1 idle cycles
        do_reset();
        gap_cycles = 16'd3;
        m_ready    = 1'b1;
        req0_valid = 1'b1; req0_data = 10'h2A0;
        tick();
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            check("tmo_wait", {s_own, s_tmo, s_mv}, {2'b01, 1'b0, 1'b0});
        end
        tick();
        check("tmo_abort", {s_tmo, s_mv, s_md, s_own, s_r0, s_r1}, {1'b1, 1'b1, 10'h100, 2'b01, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tmo_gap", {s_own, s_busy, s_tmo}, {2'b00, 1'b1, 1'b0});
        end
        tick();
        check("tmo_idle", {s_own, s_busy}, 3'b000);
`endif

        // Randomized traffic scored against per-requester transaction queues
        do_reset();
        gen_txns();
        gap_cycles = 16'd1;
        txn_own    = 2'b00;
        for (int c = 0; c < 6000; c++) begin
            if (!req0_valid && src0.size() > 0 && $urandom_range(2, 0) != 0) begin
                req0_valid = 1'b1;
                req0_data  = src0[0];
            end
            if (!req1_valid && src1.size() > 0 && $urandom_range(2, 0) != 0) begin
                req1_valid = 1'b1;
                req1_data  = src1[0];
            end
            m_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(15, 0) == 0) gap_cycles = 16'($urandom_range(3, 0));
            tick();
            if (s_r0 && s_r1) check("rnd_ready_excl", {s_r0, s_r1}, 2'b00);
            if (s_tmo) check("rnd_tmo_quiet", s_tmo, 1'b0);
            if (s_beat) begin
                check("rnd_beat_owner", (s_own == 2'b01 || s_own == 2'b10), 1'b1);
                check("rnd_beat_src", {s_r1, s_r0}, s_own);
                if (txn_own != 2'b00) check("rnd_no_interleave", s_own, txn_own);
                if (s_own == 2'b01) begin
                    check("rnd_avail0", exp0.size() > 0, 1'b1);
                    if (exp0.size() > 0) check("rnd_data0", s_md, exp0.pop_front());
                end else if (s_own == 2'b10) begin
                    check("rnd_avail1", exp1.size() > 0, 1'b1);
                    if (exp1.size() > 0) check("rnd_data1", s_md, exp1.pop_front());
                end
                txn_own = s_md[8] ? 2'b00 : s_own;
            end
            if (req0_valid && s_r0) begin
                void'(src0.pop_front());
                req0_valid = 1'b0;
            end
            if (req1_valid && s_r1) begin
                void'(src1.pop_front());
                req1_valid = 1'b0;
            end
            if (src0.size() == 0 && src1.size() == 0 && !req0_valid && !req1_valid) break;
        end
        check("rnd_drain0", exp0.size(), 0);
        check("rnd_drain1", exp1.size(), 0);
        check("rnd_src_empty", src0.size() + src1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
